// File: rtl/ann_class_smoother.sv
// Debounces the per-beat argmax of four signed ANN scores into a stable class.
// Two-stage pipeline with a single global advance so the whole path stalls together.
module ann_class_smoother #(
  parameter int unsigned HOLD_COUNT = 3,
  parameter int unsigned MIN_MARGIN = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] o0,
  input  logic signed [15:0] o1,
  input  logic signed [15:0] o2,
  input  logic signed [15:0] o3,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         raw_class,
  output logic [1:0]         stable_class,
  output logic               stable_ok,
  output logic               class_change,
  output logic [15:0]        top_mag,
  output logic [15:0]        margin
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned NS = 4;

  typedef enum logic [0:0] {EMPTY = 1'b0, LOCKED = 1'b1} state_t;

  // Magnitude with the most negative code saturated to the largest positive one
  function automatic logic [DW-1:0] mag_of(input logic signed [DW-1:0] x);
    if (!x[DW-1])
      return DW'(x);
    else if (x == {1'b1, {(DW-1){1'b0}}})
      return {1'b0, {(DW-1){1'b1}}};
    else
      return DW'(-x);
  endfunction

  logic          en;
  logic          a_valid;
  logic [DW-1:0] a_mag [NS];

  state_t        state, state_n;
  logic [1:0]    candidate, cand_n;
  logic [CW-1:0] count, cnt_n;
  logic [1:0]    stable_n;
  logic          change_n;

  logic [1:0]    win;
  logic [DW-1:0] top, second, mar;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage A: register input magnitudes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid <= 1'b0;
      for (int i = 0; i < NS; i++) a_mag[i] <= '0;
    end else if (en) begin
      a_valid <= in_valid;
      if (in_valid) begin
        a_mag[0] <= mag_of(o0);
        a_mag[1] <= mag_of(o1);
        a_mag[2] <= mag_of(o2);
        a_mag[3] <= mag_of(o3);
      end
    end
  end

  // Argmax with lowest-index tie break, then margin over the best of the rest
  always_comb begin
    win    = 2'd0;
    top    = a_mag[0];
    second = '0;
    for (int i = 1; i < NS; i++) begin
      if (a_mag[i] > top) begin
        top = a_mag[i];
        win = 2'(i);
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (2'(i) != win && a_mag[i] > second) second = a_mag[i];
    end
    mar = top - second;
  end

  // Debounce next-state for a beat entering stage B
  always_comb begin
    state_n  = state;
    cand_n   = candidate;
    cnt_n    = count;
    stable_n = stable_class;
    change_n = 1'b0;
    if (mar >= DW'(MIN_MARGIN)) begin
      if (win == candidate) begin
        if (count < CW'(HOLD_COUNT)) cnt_n = count + CW'(1);
      end else begin
        cand_n = win;
        cnt_n  = CW'(1);
      end
      if (cnt_n == CW'(HOLD_COUNT)) begin
        if (state == EMPTY) begin
          stable_n = cand_n;
          state_n  = LOCKED;
          change_n = 1'b1;
        end else if (cand_n != stable_class) begin
          stable_n = cand_n;
          change_n = 1'b1;
        end
      end
    end else begin
      cnt_n = '0;
    end
  end

  // Stage B: result and debounce state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      raw_class    <= '0;
      top_mag      <= '0;
      margin       <= '0;
      stable_class <= '0;
      stable_ok    <= 1'b0;
      class_change <= 1'b0;
      state        <= EMPTY;
      candidate    <= '0;
      count        <= '0;
    end else if (en) begin
      out_valid <= a_valid;
      if (a_valid) begin
        raw_class    <= win;
        top_mag      <= top;
        margin       <= mar;
        candidate    <= cand_n;
        count        <= cnt_n;
        state        <= state_n;
        stable_class <= stable_n;
        stable_ok    <= (state_n == LOCKED);
        class_change <= change_n;
      end else begin
        class_change <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ann_class_smoother.sv
// Directed bench: table of per-beat argmax/margin vectors plus hand-built
// sequences for debounce, backpressure and mid-flight reset.
module tb_ann_class_smoother;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] o0, o1, o2, o3;
  logic               in_valid, in_ready, out_valid, out_ready;
  logic [1:0]         raw_class, stable_class;
  logic               stable_ok, class_change;
  logic [15:0]        top_mag, margin;

  int errors = 0;
  int checks = 0;

  ann_class_smoother #(.HOLD_COUNT(3), .MIN_MARGIN(16)) dut (
    .clk(clk), .rst(rst), .o0(o0), .o1(o1), .o2(o2), .o3(o3),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .raw_class(raw_class), .stable_class(stable_class),
    .stable_ok(stable_ok), .class_change(class_change), .top_mag(top_mag),
    .margin(margin)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] a, b, c, d;
    logic [1:0]         raw;
    logic [15:0]        top, mar;
  } vec_t;

  typedef struct {
    logic signed [15:0] a, b, c, d;
    logic [1:0]         raw;
    logic [1:0]         stable;
    logic               ok, chg;
  } fsm_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    o0 = '0; o1 = '0; o2 = '0; o3 = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Present one beat for one cycle; returns at the negedge after acceptance
  task automatic push(input logic signed [15:0] a, b, c, d);
    @(negedge clk);
    o0 = a; o1 = b; o2 = c; o3 = d; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic fsm_beat(input string name, input fsm_t v);
    push(v.a, v.b, v.c, v.d);
    @(negedge clk);
    check({name, " valid"}, 32'(out_valid), 32'd1);
    check({name, " raw"}, 32'(raw_class), 32'(v.raw));
    check({name, " stable"}, 32'(stable_class), 32'(v.stable));
    check({name, " ok"}, 32'(stable_ok), 32'(v.ok));
    check({name, " change"}, 32'(class_change), 32'(v.chg));
  endtask

  vec_t tbl[8];
  fsm_t seq4[4];
  fsm_t seq5[6];
  fsm_t seqm[4];
  vec_t strm[4];

  initial begin
    vec_t        got_q[$];
    vec_t        snap;
    int          idx;
    logic        snap_ok;

    tbl[0] = '{16'sd100, -16'sd300, 16'sd50, 16'sd20, 2'd1, 16'd300, 16'd200};
    tbl[1] = '{16'sd200, -16'sd200, 16'sd5, 16'sd5, 2'd0, 16'd200, 16'd0};
    tbl[2] = '{16'sd10, 16'sd20, 16'sd30, 16'sh8000, 2'd3, 16'd32767, 16'd32737};
    tbl[3] = '{-16'sd5, -16'sd5, -16'sd5, -16'sd5, 2'd0, 16'd5, 16'd0};
    tbl[4] = '{16'sd0, 16'sd0, 16'sd0, 16'sd32767, 2'd3, 16'd32767, 16'd32767};
    tbl[5] = '{16'sh8000, 16'sd32767, 16'sd0, 16'sd0, 2'd0, 16'd32767, 16'd0};
    tbl[6] = '{16'sd7, 16'sd100, -16'sd100, 16'sd3, 2'd1, 16'd100, 16'd0};
    tbl[7] = '{16'sd1000, -16'sd984, 16'sd0, 16'sd0, 2'd0, 16'd1000, 16'd16};

    seq4[0] = '{16'sd0, 16'sd0, 16'sd500, 16'sd100, 2'd2, 2'd0, 1'b0, 1'b0};
    seq4[1] = '{16'sd0, 16'sd0, 16'sd500, 16'sd100, 2'd2, 2'd0, 1'b0, 1'b0};
    seq4[2] = '{16'sd0, 16'sd0, 16'sd500, 16'sd100, 2'd2, 2'd2, 1'b1, 1'b1};
    seq4[3] = '{16'sd0, 16'sd0, 16'sd500, 16'sd100, 2'd2, 2'd2, 1'b1, 1'b0};

    seq5[0] = '{16'sd0, 16'sd500, 16'sd0, 16'sd0, 2'd1, 2'd2, 1'b1, 1'b0};
    seq5[1] = '{16'sd0, 16'sd500, 16'sd0, 16'sd0, 2'd1, 2'd2, 1'b1, 1'b0};
    seq5[2] = '{16'sd100, 16'sd90, 16'sd0, 16'sd0, 2'd0, 2'd2, 1'b1, 1'b0};
    seq5[3] = '{16'sd0, 16'sd500, 16'sd0, 16'sd0, 2'd1, 2'd2, 1'b1, 1'b0};
    seq5[4] = '{16'sd0, 16'sd500, 16'sd0, 16'sd0, 2'd1, 2'd2, 1'b1, 1'b0};
    seq5[5] = '{16'sd0, 16'sd500, 16'sd0, 16'sd0, 2'd1, 2'd1, 1'b1, 1'b1};

    // Margin exactly 16 is confident; 15 is not and must not disturb the lock
    seqm[0] = '{16'sd1000, -16'sd984, 16'sd0, 16'sd0, 2'd0, 2'd1, 1'b1, 1'b0};
    seqm[1] = '{16'sd1000, -16'sd984, 16'sd0, 16'sd0, 2'd0, 2'd1, 1'b1, 1'b0};
    seqm[2] = '{16'sd1000, -16'sd984, 16'sd0, 16'sd0, 2'd0, 2'd0, 1'b1, 1'b1};
    seqm[3] = '{16'sd0, 16'sd1000, -16'sd985, 16'sd0, 2'd1, 2'd0, 1'b1, 1'b0};

    strm[0] = '{16'sd1, 16'sd50, 16'sd2, 16'sd3, 2'd1, 16'd50, 16'd47};
    strm[1] = '{16'sd9, 16'sd1, 16'sd2, -16'sd70, 2'd3, 16'd70, 16'd61};
    strm[2] = '{-16'sd400, 16'sd1, 16'sd2, 16'sd3, 2'd0, 16'd400, 16'd397};
    strm[3] = '{16'sd4, 16'sd1, 16'sd60, 16'sd3, 2'd2, 16'd60, 16'd56};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    o0 = '0; o1 = '0; o2 = '0; o3 = '0;
    do_reset();
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst raw", 32'(raw_class), 32'd0);
    check("rst stable", 32'(stable_class), 32'd0);
    check("rst ok", 32'(stable_ok), 32'd0);
    check("rst change", 32'(class_change), 32'd0);
    check("rst top", 32'(top_mag), 32'd0);
    check("rst margin", 32'(margin), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);

    // Latency: nothing after the accept edge, result after the next one
    push(16'sd100, -16'sd300, 16'sd50, 16'sd20);
    check("lat early", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat valid", 32'(out_valid), 32'd1);

    for (int i = 0; i < 8; i++) begin
      push(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d);
      @(negedge clk);
      check($sformatf("tbl%0d valid", i), 32'(out_valid), 32'd1);
      check($sformatf("tbl%0d raw", i), 32'(raw_class), 32'(tbl[i].raw));
      check($sformatf("tbl%0d top", i), 32'(top_mag), 32'(tbl[i].top));
      check($sformatf("tbl%0d margin", i), 32'(margin), 32'(tbl[i].mar));
      check($sformatf("tbl%0d noprog", i), 32'(stable_ok), 32'd0);
    end
    @(negedge clk);
    check("bubble clears valid", 32'(out_valid), 32'd0);

    do_reset();
    for (int i = 0; i < 4; i++) fsm_beat($sformatf("lock%0d", i), seq4[i]);
    for (int i = 0; i < 6; i++) fsm_beat($sformatf("switch%0d", i), seq5[i]);
    for (int i = 0; i < 4; i++) fsm_beat($sformatf("mbound%0d", i), seqm[i]);

    // Backpressure: stream four beats, stall the consumer for five cycles
    do_reset();
    idx = 0;
    snap_ok = 1'b0;
    snap = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 2'd0, 16'd0, 16'd0};
    for (int cyc = 0; cyc < 40 && got_q.size() < 4; cyc++) begin
      @(negedge clk);
      in_valid  = (idx < 4);
      if (idx < 4) begin
        o0 = strm[idx].a; o1 = strm[idx].b; o2 = strm[idx].c; o3 = strm[idx].d;
      end
      out_ready = !(cyc >= 3 && cyc <= 7);
      #1;
      if (cyc == 3) begin
        check("stall valid", 32'(out_valid), 32'd1);
        check("stall in_ready", 32'(in_ready), 32'd0);
        snap = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, raw_class, top_mag, margin};
        snap_ok = 1'b1;
      end else if (cyc > 3 && cyc <= 7 && snap_ok) begin
        check($sformatf("stall%0d hold", cyc),
              {out_valid, in_ready, 14'd0, top_mag},
              {1'b1, 1'b0, 14'd0, snap.top});
        check($sformatf("stall%0d raw", cyc), 32'(raw_class), 32'(snap.raw));
        check($sformatf("stall%0d margin", cyc), 32'(margin), 32'(snap.mar));
      end
      if (out_valid && out_ready)
        got_q.push_back('{16'sd0, 16'sd0, 16'sd0, 16'sd0, raw_class, top_mag, margin});
      if (in_valid && in_ready) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("stream count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      check($sformatf("stream%0d raw", i), 32'(got_q[i].raw), 32'(strm[i].raw));
      check($sformatf("stream%0d top", i), 32'(got_q[i].top), 32'(strm[i].top));
      check($sformatf("stream%0d margin", i), 32'(got_q[i].mar), 32'(strm[i].mar));
    end

    // Reset between accept and output discards in-flight beats at once
    do_reset();
    @(negedge clk);
    o0 = 16'sd0; o1 = 16'sd900; o2 = 16'sd0; o3 = 16'sd0; in_valid = 1'b1;
    @(negedge clk);
    o0 = 16'sd0; o1 = 16'sd0; o2 = 16'sd0; o3 = 16'sd700;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre-rst valid", 32'(out_valid), 32'd1);
    check("pre-rst top", 32'(top_mag), 32'd900);
    #2 rst = 1'b1;
    #1;
    check("async rst valid", 32'(out_valid), 32'd0);
    check("async rst outs",
          {24'd0, raw_class, stable_class, stable_ok, class_change, 2'd0},
          32'd0);
    check("async rst top", 32'(top_mag), 32'd0);
    check("async rst margin", 32'(margin), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("no stale %0d", i), 32'(out_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
